// File: rtl/obstacle_scheduler.sv
// Traffic sequencer: generates the car move strobe, picks the move period from
// score at level-up, owns the per-lane direction bits and freezes traffic during holds.
module obstacle_scheduler #(
  parameter int                  C_BASE_PERIOD  = 781250,
  parameter int                  NUM_LANES      = 4,
  parameter logic [NUM_LANES-1:0] C_REVERSE_INIT = 4'b1010,
  parameter int                  C_HIT_HOLD     = 12500000,
  parameter int                  C_LEVEL_HOLD   = 25000000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Game_Start,
  input  logic                 i_Game_Over,
  input  logic                 i_Frog_Hit,
  input  logic                 i_Level_Up,
  input  logic [3:0]           i_Score,
  output logic                 o_Move_Tick,
  output logic [NUM_LANES-1:0] o_Reverse,
  output logic [19:0]          o_Period,
  output logic [3:0]           o_Level,
  output logic [1:0]           o_State
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_HIT_HOLD   = 2'd2;
  localparam logic [1:0] ST_LEVEL_HOLD = 2'd3;

  localparam int HOLD_MAX = (C_HIT_HOLD > C_LEVEL_HOLD) ? C_HIT_HOLD : C_LEVEL_HOLD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [19:0]       BASE_PERIOD = 20'(C_BASE_PERIOD);
  localparam logic [HOLD_W-1:0] HIT_LAST    = HOLD_W'(C_HIT_HOLD - 1);
  localparam logic [HOLD_W-1:0] LEVEL_LAST  = HOLD_W'(C_LEVEL_HOLD - 1);

  logic [1:0]           state_q, state_d;
  logic                 tick_q, tick_d;
  logic [NUM_LANES-1:0] rev_q, rev_d;
  logic [19:0]          period_q, period_d;
  logic [3:0]           level_q, level_d;
  logic [19:0]          move_q, move_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [NUM_LANES-1:0] rev_rot;
  logic [19:0]          period_sel;

  // Rotate left by one lane: MSB wraps into bit 0.
  always_comb begin
    rev_rot = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rev_rot[i] = rev_q[(i + NUM_LANES - 1) % NUM_LANES];
    end
  end

  always_comb begin
    if (i_Score <= 4'd3) begin
      period_sel = BASE_PERIOD;
    end else if (i_Score <= 4'd6) begin
      period_sel = BASE_PERIOD >> 1;
    end else if (i_Score <= 4'd9) begin
      period_sel = BASE_PERIOD >> 2;
    end else begin
      period_sel = BASE_PERIOD >> 3;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = 1'b0;
    rev_d    = rev_q;
    period_d = period_q;
    level_d  = level_q;
    move_d   = move_q;
    hold_d   = hold_q;

    if (i_Game_Over) begin
      state_d = ST_IDLE;
      move_d  = '0;
      hold_d  = '0;
    end else if (i_Game_Start) begin
      state_d  = ST_RUN;
      period_d = BASE_PERIOD;
      rev_d    = C_REVERSE_INIT;
      level_d  = 4'd0;
      move_d   = '0;
      hold_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (i_Frog_Hit) begin
            state_d = ST_HIT_HOLD;
            hold_d  = '0;
            move_d  = '0;
          end else if (i_Level_Up) begin
            state_d  = ST_LEVEL_HOLD;
            hold_d   = '0;
            move_d   = '0;
            level_d  = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            rev_d    = rev_rot;
            period_d = period_sel;
          end else if (move_q == period_q - 20'd1) begin
            // Tick only when RUN continues; any accepted event above suppresses it.
            move_d = '0;
            tick_d = 1'b1;
          end else begin
            move_d = move_q + 20'd1;
          end
        end
        ST_HIT_HOLD: begin
          if (hold_q == HIT_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
            move_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_LEVEL_HOLD: begin
          if (hold_q == LEVEL_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
            move_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          move_d = '0;
          hold_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      tick_q   <= 1'b0;
      rev_q    <= C_REVERSE_INIT;
      period_q <= BASE_PERIOD;
      level_q  <= 4'd0;
      move_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      rev_q    <= rev_d;
      period_q <= period_d;
      level_q  <= level_d;
      move_q   <= move_d;
      hold_q   <= hold_d;
    end
  end

  assign o_Move_Tick = tick_q;
  assign o_Reverse   = rev_q;
  assign o_Period    = period_q;
  assign o_Level     = level_q;
  assign o_State     = state_q;

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Sequences the car-movement datapath: generates the periodic move strobe, selects the move period from score, and owns per-lane direction (reverse) bits. It freezes traffic while the frog-hit animation and level-up banner play. It sits between the game-state logic (start/over/hit/level-up pulses) and the obstacle position datapath, which advances car X positions only on o_Move_Tick.

Parameters:
C_BASE_PERIOD, 781250, move period in clocks at lowest difficulty; must be >= 8 and < 2^20
NUM_LANES, 4, number of reverse bits driven
C_REVERSE_INIT, 4'b1010, o_Reverse value after reset/game start (NUM_LANES bits)
C_HIT_HOLD, 12500000, freeze length in clocks after a frog hit; must be >= 1
C_LEVEL_HOLD, 25000000, freeze length in clocks after a level-up; must be >= 1

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Game_Start  in  1  1-cycle pulse: start or restart game
i_Game_Over  in  1  1-cycle pulse: stop traffic
i_Frog_Hit  in  1  1-cycle pulse: frog collided
i_Level_Up  in  1  1-cycle pulse: frog reached goal
i_Score  in  4  current score, sampled only on level-up acceptance
o_Move_Tick  out  1  1-cycle strobe: datapath advances cars
o_Reverse  out  NUM_LANES  per-lane direction, 1 = moving left
o_Period  out  20  active move period in clocks
o_Level  out  4  accepted level-ups, saturates at 15
o_State  out  2  FSM state: IDLE=0, RUN=1, HIT_HOLD=2, LEVEL_HOLD=3

Behaviour:
- Reset (async, i_Rst_L=0): o_State=IDLE, o_Move_Tick=0, o_Reverse=C_REVERSE_INIT, o_Period=C_BASE_PERIOD, o_Level=0, move and hold counters=0. All outputs registered.
- Event priority, evaluated every cycle in every state: Game_Over > Game_Start > Frog_Hit > Level_Up. Lower-priority pulses in the same cycle are dropped.
- i_Game_Over: state->IDLE, move counter cleared, o_Move_Tick=0 next cycle. o_Reverse, o_Period, and o_Level hold.
- i_Game_Start (any state): state->RUN, o_Period=C_BASE_PERIOD, o_Reverse=C_REVERSE_INIT, o_Level=0, move counter=0.
- IDLE: no ticks. Frog_Hit and Level_Up are ignored.
- RUN: 20-bit move counter increments each cycle. When counter == o_Period-1, it clears and o_Move_Tick=1 on the next cycle. First tick appears exactly o_Period cycles after RUN entry, then one every o_Period cycles.
- RUN + i_Frog_Hit: state->HIT_HOLD, hold counter=0, move counter cleared. Period, reverse, and level are unchanged.
- RUN + i_Level_Up: state->LEVEL_HOLD, hold counter=0, move counter cleared.
  - o_Level = min(o_Level+1, 15).
  - o_Reverse rotated left by 1 (MSB wraps into bit 0).
  - o_Period from i_Score that cycle: 0-3 -> base; 4-6 -> base>>1; 7-9 -> base>>2; 10-15 -> base>>3.
- HIT_HOLD / LEVEL_HOLD: no ticks. Hold counter increments. At hold == C_*_HOLD-1, state->RUN with move counter 0. Frog_Hit and Level_Up are ignored during holds; Game_Over and Game_Start still act.
- A tick pending from the final RUN cycle is suppressed if an event leaves RUN in that same cycle. o_Move_Tick is never asserted outside RUN-derived counting.
- i_Score changes outside level-up acceptance do not affect o_Period.
- Reset asserted mid-operation: immediate return to reset values; no tick is emitted on release until a Game_Start arrives.

Test Plan:
(bench params: C_BASE_PERIOD=16, C_HIT_HOLD=5, C_LEVEL_HOLD=8, C_REVERSE_INIT=4'b1010)
1. Reset, 40 idle cycles, then Game_Start at cycle 0 -> no ticks before start; o_State=1; ticks at cycles 16, 32, 48, each 1 cycle wide.
2. RUN, Level_Up with i_Score=5 -> o_State=3 for 8 cycles, o_Reverse=4'b0101, o_Level=1, o_Period=8; first tick 8 cycles after RUN re-entry, then every 8.
3. Successive Level_Ups with i_Score=7 then 12 -> o_Period=4 then 2. o_Reverse sequence 0101 -> 1010 -> 0101. Sixteen further level-ups -> o_Level saturates at 15.
4. Frog_Hit and Level_Up in the same cycle during RUN -> HIT_HOLD for 5 cycles; o_Level, o_Period, and o_Reverse unchanged. Level_Up pulsed inside the hold is ignored.
5. Game_Over and Game_Start in the same cycle -> o_State=0, no further ticks. A later Game_Start restores o_Period=16, o_Reverse=1010, o_Level=0.
6. i_Rst_L low for 1 cycle mid-RUN, asynchronous to the clock edge -> outputs at reset values immediately; no tick until the next Game_Start.
